// File: rtl/input_conditioner_pkg.sv
// Shared constants for the push-button input conditioner: debounce
// FSM state encoding and default timing parameters.
package input_conditioner_pkg;

  // Debounce FSM state encoding. Bit 1 set means the accepted level is high.
  localparam logic [1:0] ST_STABLE_LO = 2'b00;
  localparam logic [1:0] ST_WAIT_HI   = 2'b01;
  localparam logic [1:0] ST_STABLE_HI = 2'b11;
  localparam logic [1:0] ST_WAIT_LO   = 2'b10;

  // 50000 cycles is 1 ms at a 50 MHz system clock.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEFAULT_CNT_WIDTH       = 16;

  // Accepted level for a given state: high in STABLE_HI and WAIT_LO.
  function automatic logic state_level(input logic [1:0] state);
    return state[1];
  endfunction

endpackage : input_conditioner_pkg

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, debounce FSM with a
// qualification counter, and registered level / press-pulse outputs.
//
// state     | meaning
// ----------+---------------------------------------------------------
// STABLE_LO | released; waiting for the synchronized input to go high
// WAIT_HI   | input high, counting; any low sample rejects the press
// STABLE_HI | pressed; waiting for the synchronized input to go low
// WAIT_LO   | input low, counting; any high sample cancels the release
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic level_o,
  output logic pulse_o
);

  // Entry into WAIT already costs one edge, so the window ends at D-2.
  localparam logic [CNT_WIDTH-1:0] CNT_TC = CNT_WIDTH'(DEBOUNCE_CYCLES - 2);

  logic                 s1_q, s2_q;
  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 pulse_q, pulse_d;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= in_i;
      s2_q <= s1_q;
    end
  end

  // Next-state, counter and output decode for the debounce FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_STABLE_LO: begin
        if (s2_q) begin
          state_d = ST_WAIT_HI;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!s2_q) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_STABLE_HI: begin
        if (!s2_q) begin
          state_d = ST_WAIT_LO;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (s2_q) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_STABLE_LO;
        cnt_d   = '0;
      end
    endcase
    // Outputs are decoded from the next state so they register alongside it.
    level_d = state_level(state_d);
    pulse_d = (state_q == ST_WAIT_HI) && (state_d == ST_STABLE_HI);
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule : debounce_channel

// File: rtl/input_conditioner.sv
// Conditions the two raw push-button inputs into clean levels and
// one-cycle press strobes for the downstream two-input FSM.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH,
  parameter bit          ACTIVE_LOW_IN   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn1_raw,
  input  logic btn2_raw,
  output logic w1,
  output logic w2,
  output logic w1_pulse,
  output logic w2_pulse
);

  logic btn1_in, btn2_in;

  // Board keys are active-low; normalize to 1 = pressed before synchronizing.
  assign btn1_in = ACTIVE_LOW_IN ? ~btn1_raw : btn1_raw;
  assign btn2_in = ACTIVE_LOW_IN ? ~btn2_raw : btn2_raw;

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_WIDTH       (CNT_WIDTH)
  ) u_ch1 (
    .clk_i   (clk),
    .rst_i   (reset),
    .in_i    (btn1_in),
    .level_o (w1),
    .pulse_o (w1_pulse)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_WIDTH       (CNT_WIDTH)
  ) u_ch2 (
    .clk_i   (clk),
    .rst_i   (reset),
    .in_i    (btn2_in),
    .level_o (w2),
    .pulse_o (w2_pulse)
  );

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Testbench for input_conditioner: directed scenarios followed by random
// button activity, checked every cycle against a run-length reference model.
module tb_input_conditioner;

  localparam int D = 8;

  logic clk = 1'b0;
  logic reset;
  logic btn1_raw, btn2_raw;
  logic w1, w2, w1_pulse, w2_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 2-sample delay line, then accept a new level once it
  // has been seen for D consecutive cycles.
  bit m_s1[2], m_s2[2], m_lvl[2], m_pulse[2];
  int m_run[2];

  input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .CNT_WIDTH       (16),
    .ACTIVE_LOW_IN   (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn1_raw (btn1_raw),
    .btn2_raw (btn2_raw),
    .w1       (w1),
    .w2       (w2),
    .w1_pulse (w1_pulse),
    .w2_pulse (w2_pulse)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_pulse[c] = 0; m_run[c] = 0;
    end
  endfunction

  function automatic void model_edge(input bit p1, input bit p2);
    bit pin[2];
    bit seen;
    pin[0] = p1;
    pin[1] = p2;
    for (int c = 0; c < 2; c++) begin
      seen       = m_s2[c];
      m_pulse[c] = 0;
      if (seen == m_lvl[c]) begin
        m_run[c] = 0;
      end else begin
        m_run[c]++;
        if (m_run[c] == D) begin
          m_lvl[c]   = seen;
          m_pulse[c] = seen;
          m_run[c]   = 0;
        end
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = pin[c];
    end
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("w1",       w1,       m_lvl[0]);
    check("w2",       w2,       m_lvl[1]);
    check("w1_pulse", w1_pulse, m_pulse[0]);
    check("w2_pulse", w2_pulse, m_pulse[1]);
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge(~btn1_raw, ~btn2_raw);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic async_reset_pulse();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    reset = 1'b0;
  endtask

  logic seen_any;

  initial begin
    reset    = 1'b1;
    btn1_raw = 1'b1;
    btn2_raw = 1'b1;
    model_reset();
    #2;
    check("rst_w1", w1, 1'b0);
    check("rst_w2", w2, 1'b0);
    check("rst_p1", w1_pulse, 1'b0);
    check("rst_p2", w2_pulse, 1'b0);
    ticks(2);
    reset = 1'b0;
    ticks(3);

    // Clean press on button 1: accepted on the 10th edge, pulse for one cycle.
    btn1_raw = 1'b0;
    ticks(9);
    check("press_w1_early", w1, 1'b0);
    tick();
    check("press_w1", w1, 1'b1);
    check("press_p1", w1_pulse, 1'b1);
    check("press_w2_idle", w2, 1'b0);
    tick();
    check("press_p1_single", w1_pulse, 1'b0);
    ticks(3);

    // Bounce on button 2: low 5, high 1, then low and hold.
    btn2_raw = 1'b0;
    ticks(5);
    btn2_raw = 1'b1;
    tick();
    btn2_raw = 1'b0;
    ticks(9);
    check("bounce_w2_early", w2, 1'b0);
    tick();
    check("bounce_w2", w2, 1'b1);
    check("bounce_p2", w2_pulse, 1'b1);
    ticks(3);

    // Release both: level drops 10 edges later, no pulse on release.
    btn1_raw = 1'b1;
    btn2_raw = 1'b1;
    seen_any = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      seen_any = seen_any | w1_pulse;
    end
    check("release_w1_held", w1, 1'b1);
    tick();
    seen_any = seen_any | w1_pulse;
    check("release_w1", w1, 1'b0);
    check("release_no_pulse", seen_any, 1'b0);
    ticks(4);

    // 7-cycle glitch on button 1 never qualifies.
    btn1_raw = 1'b0;
    seen_any = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      seen_any = seen_any | w1 | w1_pulse;
    end
    btn1_raw = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen_any = seen_any | w1 | w1_pulse;
    end
    check("glitch_ignored", seen_any, 1'b0);

    // Simultaneous press: both pulses in the same cycle.
    btn1_raw = 1'b0;
    btn2_raw = 1'b0;
    ticks(10);
    check("simul_p1", w1_pulse, 1'b1);
    check("simul_p2", w2_pulse, 1'b1);
    btn1_raw = 1'b1;
    btn2_raw = 1'b1;
    ticks(12);

    // Reset partway through a qualifying window, buttons held throughout.
    btn1_raw = 1'b0;
    btn2_raw = 1'b0;
    ticks(7);
    async_reset_pulse();
    ticks(9);
    check("rst_hold_p1_early", w1_pulse, 1'b0);
    tick();
    check("rst_hold_p1", w1_pulse, 1'b1);
    check("rst_hold_p2", w2_pulse, 1'b1);
    btn1_raw = 1'b1;
    btn2_raw = 1'b1;
    ticks(12);

    // Random segments of button activity with occasional resets.
    for (int s = 0; s < 60; s++) begin
      btn1_raw = 1'($urandom_range(0, 1));
      btn2_raw = 1'($urandom_range(0, 1));
      ticks($urandom_range(1, 20));
      if ($urandom_range(0, 15) == 0) async_reset_pulse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_input_conditioner
